// File: rtl/writeback_responder_pkg.sv
// Shared types and widths for the ALU writeback responder.
package writeback_responder_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    REG_IDLE,
    REG_ACK
  } wb_reg_state_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_ISSUE,
    MEM_ACK
  } wb_mem_state_t;

  typedef enum logic {
    PC_IDLE,
    PC_ACK
  } wb_pc_state_t;

endpackage

// File: rtl/writeback_responder_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear on reset.
module reg_file
  import writeback_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]       rd_data_a,
  output logic [XLEN-1:0]       rd_data_b
);

  logic [XLEN-1:0] regs [32];

  // Clear all entries on reset; otherwise commit writes, discarding x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // No write bypass: a write shows up only after its commit edge.
  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/writeback_responder.sv
// Responder end of the ALU result interface: three independent channel FSMs
// commit register writes, memory writes and PC branches, returning acks.
module writeback_responder
  import writeback_responder_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg_wr_data,
  input  logic [4:0]  reg_wr_addr,
  input  logic        reg_wr_data_valid,
  output logic        reg_wr_ack,
  input  logic [31:0] mem_wr_data,
  input  logic [31:0] mem_wr_addr,
  input  logic        mem_wr_data_valid,
  output logic        mem_wr_ack,
  input  logic [31:0] pc_branch_data,
  input  logic        pc_branch_data_valid,
  output logic        pc_branch_data_ack,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic        dmem_wr_en,
  output logic [31:0] dmem_wr_addr,
  output logic [31:0] dmem_wr_data,
  input  logic        dmem_wr_ready,
  input  logic        pc_advance,
  output logic [31:0] pc
);

  wb_reg_state_t reg_state;
  wb_mem_state_t mem_state;
  wb_pc_state_t  pc_state;
  logic          reg_commit;

  // The write lands at the same edge that accepts the request.
  assign reg_commit = (reg_state == REG_IDLE) && reg_wr_data_valid;

  reg_file u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (reg_commit),
    .wr_addr   (reg_wr_addr),
    .wr_data   (reg_wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  // Register channel: accept in IDLE, pulse ack for one cycle in ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_state  <= REG_IDLE;
      reg_wr_ack <= 1'b0;
    end else begin
      case (reg_state)
        REG_IDLE: begin
          if (reg_wr_data_valid) begin
            reg_state  <= REG_ACK;
            reg_wr_ack <= 1'b1;
          end
        end
        default: begin
          reg_state  <= REG_IDLE;
          reg_wr_ack <= 1'b0;
        end
      endcase
    end
  end

  // Memory channel: latch the write, hold the strobe until ready, then ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_state    <= MEM_IDLE;
      mem_wr_ack   <= 1'b0;
      dmem_wr_en   <= 1'b0;
      dmem_wr_addr <= '0;
      dmem_wr_data <= '0;
    end else begin
      case (mem_state)
        MEM_IDLE: begin
          if (mem_wr_data_valid) begin
            mem_state    <= MEM_ISSUE;
            dmem_wr_en   <= 1'b1;
            dmem_wr_addr <= mem_wr_addr;
            dmem_wr_data <= mem_wr_data;
          end
        end
        MEM_ISSUE: begin
          if (dmem_wr_ready) begin
            mem_state  <= MEM_ACK;
            dmem_wr_en <= 1'b0;
            mem_wr_ack <= 1'b1;
          end
        end
        default: begin
          mem_state  <= MEM_IDLE;
          mem_wr_ack <= 1'b0;
        end
      endcase
    end
  end

  // PC channel: a branch load takes priority over a same-cycle advance;
  // advances are still honoured while the branch ack is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_state           <= PC_IDLE;
      pc_branch_data_ack <= 1'b0;
      pc                 <= RESET_PC;
    end else begin
      case (pc_state)
        PC_IDLE: begin
          if (pc_branch_data_valid) begin
            pc_state           <= PC_ACK;
            pc_branch_data_ack <= 1'b1;
            pc                 <= pc_branch_data;
          end else if (pc_advance) begin
            pc <= pc + PC_STEP;
          end
        end
        default: begin
          pc_state           <= PC_IDLE;
          pc_branch_data_ack <= 1'b0;
          if (pc_advance) pc <= pc + PC_STEP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_responder.sv
// Bench for writeback_responder: register-file vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_writeback_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_wr_data;
  logic [4:0]  reg_wr_addr;
  logic        reg_wr_data_valid;
  logic        reg_wr_ack;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_wr_addr;
  logic        mem_wr_data_valid;
  logic        mem_wr_ack;
  logic [31:0] pc_branch_data;
  logic        pc_branch_data_valid;
  logic        pc_branch_data_ack;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        dmem_wr_en;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_wr_ready;
  logic        pc_advance;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_responder dut (
    .clk                  (clk),
    .reset                (reset),
    .reg_wr_data          (reg_wr_data),
    .reg_wr_addr          (reg_wr_addr),
    .reg_wr_data_valid    (reg_wr_data_valid),
    .reg_wr_ack           (reg_wr_ack),
    .mem_wr_data          (mem_wr_data),
    .mem_wr_addr          (mem_wr_addr),
    .mem_wr_data_valid    (mem_wr_data_valid),
    .mem_wr_ack           (mem_wr_ack),
    .pc_branch_data       (pc_branch_data),
    .pc_branch_data_valid (pc_branch_data_valid),
    .pc_branch_data_ack   (pc_branch_data_ack),
    .rd_addr_a            (rd_addr_a),
    .rd_addr_b            (rd_addr_b),
    .rd_data_a            (rd_data_a),
    .rd_data_b            (rd_data_b),
    .dmem_wr_en           (dmem_wr_en),
    .dmem_wr_addr         (dmem_wr_addr),
    .dmem_wr_data         (dmem_wr_data),
    .dmem_wr_ready        (dmem_wr_ready),
    .pc_advance           (pc_advance),
    .pc                   (pc)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    vecs [6];
  logic [31:0] mregs [32];
  logic [31:0] mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full register-write handshake with fixed one-cycle ack latency checks.
  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    reg_wr_addr       = a;
    reg_wr_data       = d;
    reg_wr_data_valid = 1'b1;
    tick();
    chk("reg_ack_high", {31'b0, reg_wr_ack}, 32'd1);
    reg_wr_data_valid = 1'b0;
    tick();
    chk("reg_ack_low", {31'b0, reg_wr_ack}, 32'd0);
  endtask

  task automatic branch(input logic [31:0] t);
    pc_branch_data       = t;
    pc_branch_data_valid = 1'b1;
    tick();
    chk("pc_ack_high", {31'b0, pc_branch_data_ack}, 32'd1);
    chk("pc_branch_load", pc, t);
    pc_branch_data_valid = 1'b0;
    tick();
    chk("pc_ack_low", {31'b0, pc_branch_data_ack}, 32'd0);
  endtask

  task automatic read_a(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_addr_a = a;
    #1;
    chk(name, rd_data_a, exp);
  endtask

  int en_cnt, ack_cnt, ack_cyc, last_en, bad;

  initial begin
    vecs[0] = '{5'd5,  32'h0000_0002, 32'h0000_0002};
    vecs[1] = '{5'd0,  32'h0000_00FF, 32'h0000_0000};
    vecs[2] = '{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{5'd1,  32'h0000_0001, 32'h0000_0001};
    vecs[5] = '{5'd0,  32'h1234_5678, 32'h0000_0000};

    reset = 1'b1;
    reg_wr_data = '0; reg_wr_addr = '0; reg_wr_data_valid = 1'b0;
    mem_wr_data = '0; mem_wr_addr = '0; mem_wr_data_valid = 1'b0;
    pc_branch_data = '0; pc_branch_data_valid = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; dmem_wr_ready = 1'b0; pc_advance = 1'b0;

    // Reset held three cycles
    repeat (3) tick();
    chk("rst_reg_ack", {31'b0, reg_wr_ack}, 32'd0);
    chk("rst_mem_ack", {31'b0, mem_wr_ack}, 32'd0);
    chk("rst_pc_ack", {31'b0, pc_branch_data_ack}, 32'd0);
    chk("rst_dmem_en", {31'b0, dmem_wr_en}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    for (int i = 0; i < 32; i++) read_a(i[4:0], 32'h0, "rst_rd_a");
    reset = 1'b0;
    tick();

    // Register vector table, read back through both ports
    for (int i = 0; i < 6; i++) begin
      reg_write(vecs[i].addr, vecs[i].data);
      rd_addr_b = vecs[i].addr;
      read_a(vecs[i].addr, vecs[i].exp, "tbl_rd_a");
      chk("tbl_rd_b", rd_data_b, vecs[i].exp);
    end

    // Memory write with three cycles of backpressure
    mem_wr_addr = 32'h7; mem_wr_data = 32'h2; mem_wr_data_valid = 1'b1;
    dmem_wr_ready = 1'b0;
    en_cnt = 0; ack_cnt = 0; ack_cyc = -1; last_en = -1; bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dmem_wr_en) begin
        en_cnt++;
        last_en = c;
        if (dmem_wr_addr !== 32'h7 || dmem_wr_data !== 32'h2) bad++;
      end
      if (mem_wr_ack) begin
        ack_cnt++;
        ack_cyc = c;
        mem_wr_data_valid = 1'b0;
      end
      dmem_wr_ready = (en_cnt >= 4) && dmem_wr_en;
    end
    dmem_wr_ready = 1'b0;
    chk("mem_en_cycles", en_cnt, 32'd4);
    chk("mem_payload_stable", bad, 32'd0);
    chk("mem_ack_count", ack_cnt, 32'd1);
    chk("mem_ack_after_ready", ack_cyc, last_en + 1);

    // Branch and advance in the same cycle: branch wins
    pc_branch_data = 32'h2; pc_branch_data_valid = 1'b1; pc_advance = 1'b1;
    tick();
    chk("br_adv_pc", pc, 32'h2);
    chk("br_adv_ack", {31'b0, pc_branch_data_ack}, 32'd1);
    pc_branch_data_valid = 1'b0;
    tick();
    chk("adv_in_ack_pc", pc, 32'h6);
    chk("br_ack_drop", {31'b0, pc_branch_data_ack}, 32'd0);
    pc_advance = 1'b0;

    // PC wraps modulo 2^32
    branch(32'hFFFF_FFFC);
    pc_advance = 1'b1;
    tick();
    pc_advance = 1'b0;
    chk("pc_wrap", pc, 32'h0);

    // Concurrent requests on all three channels
    reg_wr_addr = 5'd3; reg_wr_data = 32'hA; reg_wr_data_valid = 1'b1;
    mem_wr_addr = 32'h10; mem_wr_data = 32'hB; mem_wr_data_valid = 1'b1;
    pc_branch_data = 32'h40; pc_branch_data_valid = 1'b1;
    dmem_wr_ready = 1'b1;
    tick();
    chk("cc_reg_ack", {31'b0, reg_wr_ack}, 32'd1);
    chk("cc_pc_ack", {31'b0, pc_branch_data_ack}, 32'd1);
    chk("cc_mem_ack_early", {31'b0, mem_wr_ack}, 32'd0);
    chk("cc_dmem_en", {31'b0, dmem_wr_en}, 32'd1);
    chk("cc_dmem_addr", dmem_wr_addr, 32'h10);
    chk("cc_dmem_data", dmem_wr_data, 32'hB);
    reg_wr_data_valid = 1'b0; pc_branch_data_valid = 1'b0;
    tick();
    chk("cc_mem_ack", {31'b0, mem_wr_ack}, 32'd1);
    chk("cc_reg_ack_low", {31'b0, reg_wr_ack}, 32'd0);
    mem_wr_data_valid = 1'b0; dmem_wr_ready = 1'b0;
    tick();
    chk("cc_mem_ack_low", {31'b0, mem_wr_ack}, 32'd0);
    chk("cc_pc", pc, 32'h40);
    read_a(5'd3, 32'hA, "cc_reg3");

    // Reset in the middle of a stalled memory write
    mem_wr_addr = 32'h20; mem_wr_data = 32'h33; mem_wr_data_valid = 1'b1;
    tick();
    tick();
    chk("mid_issue_en", {31'b0, dmem_wr_en}, 32'd1);
    reset = 1'b1; mem_wr_data_valid = 1'b0;
    tick();
    chk("mid_rst_en", {31'b0, dmem_wr_en}, 32'd0);
    chk("mid_rst_ack", {31'b0, mem_wr_ack}, 32'd0);
    chk("mid_rst_addr", dmem_wr_addr, 32'h0);
    chk("mid_rst_data", dmem_wr_data, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    read_a(5'd3, 32'h0, "mid_rst_reg3");
    reset = 1'b0;
    tick();
    chk("post_rst_no_ack", {31'b0, mem_wr_ack}, 32'd0);
    mem_wr_addr = 32'h44; mem_wr_data = 32'h55; mem_wr_data_valid = 1'b1;
    dmem_wr_ready = 1'b1;
    tick();
    chk("post_rst_en", {31'b0, dmem_wr_en}, 32'd1);
    chk("post_rst_addr", dmem_wr_addr, 32'h44);
    tick();
    chk("post_rst_ack", {31'b0, mem_wr_ack}, 32'd1);
    mem_wr_data_valid = 1'b0; dmem_wr_ready = 1'b0;
    tick();

    // Randomized register writes, advances and branches against the model
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpc = 32'h0;
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        logic [4:0]  a;
        logic [31:0] d;
        a = 5'($urandom_range(0, 31));
        d = $urandom;
        reg_write(a, d);
        if (a != 5'd0) mregs[a] = d;
      end else if (op == 1) begin
        int n;
        n = $urandom_range(1, 3);
        pc_advance = 1'b1;
        repeat (n) tick();
        pc_advance = 1'b0;
        mpc = mpc + 32'(4 * n);
      end else begin
        logic [31:0] t;
        t = $urandom;
        branch(t);
        mpc = t;
      end
      begin
        logic [4:0] ra, rb;
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
        rd_addr_b = rb;
        read_a(ra, mregs[ra], "rnd_rd_a");
        chk("rnd_rd_b", rd_data_b, mregs[rb]);
      end
      chk("rnd_pc", pc, mpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
